// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package rf_ctrl_pkg;

    typedef enum logic [0:0] {StClear, StArb} state_e;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned X0_ADDR    = 0;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: grants a lone requester directly, and on a
// conflict grants the side the pointer favours; the pointer then moves to the loser.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    // After a grant to req0 the pointer favours req1, and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: round-robin between ALU and load writeback,
// drops x0 writes. RF_CLEAR_ON_RESET_EN adds a post-reset zeroing sequence.
module regfile_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              v0,
    input  logic [ADDR_W-1:0] a0,
    input  logic [DATA_W-1:0] d0,
    output logic              r0,
    input  logic              v1,
    input  logic [ADDR_W-1:0] a1,
    input  logic [DATA_W-1:0] d1,
    output logic              r1,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [DATA_W-1:0] rf_WD3,
    output logic              rf_WE3,
    output logic              busy
);

    logic [1:0]        req, gnt;
    logic              arb_en, accept, clearing;
    logic [ADDR_W-1:0] clr_addr, acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              we3_q, we3_d;

`ifdef RF_CLEAR_ON_RESET_EN
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == LastIdx) begin
                state_d   = StArb;
                clr_idx_d = '0;
            end
        end
    end

    always_comb begin
        clearing = (state_q == StClear);
        arb_en   = !clearing && !rst;
        clr_addr = clr_idx_q;
    end
`else
    assign clearing = 1'b0;
    assign arb_en   = !rst;
    assign clr_addr = '0;
`endif

    assign req = {v1, v0} & {2{arb_en}};

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk_i    (CLK),
        .rst_i    (rst),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign accept   = |gnt;
    assign acc_addr = gnt[1] ? a1 : a0;
    assign acc_data = gnt[1] ? d1 : d0;

    // Address/data hold when idle; only the enable is pulsed.
    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (clearing) begin
            we3_d = 1'b1;
            a3_d  = clr_addr;
            wd3_d = '0;
        end else if (accept) begin
            a3_d  = acc_addr;
            wd3_d = acc_data;
            we3_d = (acc_addr != ADDR_W'(X0_ADDR));
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign r0     = gnt[0];
    assign r1     = gnt[1];
    assign rf_WE3 = we3_q;
    assign rf_A3  = a3_q;
    assign rf_WD3 = wd3_q;
    assign busy   = clearing;

endmodule
